// File: rtl/nco_iq_unpack_axis.sv
// Unpacks a packed DDS AXI-Stream word into signed I/Q samples, with optional
// conjugate, truncate/round-saturate width reduction, and a 2-entry skid buffer.

module nco_iq_lane #(
  parameter int DDS_WIDTH  = 16,
  parameter int O_WIDTH    = 12,
  parameter int ROUND_MODE = 0
) (
  input  logic [DDS_WIDTH-1:0] x,
  input  logic                 neg,
  output logic [O_WIDTH-1:0]   y,
  output logic                 sat
);
  localparam int S = DDS_WIDTH - O_WIDTH;
  localparam logic [DDS_WIDTH-1:0] DMIN = {1'b1, {(DDS_WIDTH-1){1'b0}}};
  localparam logic [DDS_WIDTH-1:0] DMAX = {1'b0, {(DDS_WIDTH-1){1'b1}}};
  localparam logic [O_WIDTH-1:0]   OMAX = {1'b0, {(O_WIDTH-1){1'b1}}};

  logic [DDS_WIDTH-1:0] v;
  logic                 neg_sat;

  // Negating the most negative code has no representation; clamp to max.
  always_comb begin
    neg_sat = neg && (x == DMIN);
    v       = neg_sat ? DMAX : (neg ? -x : x);
  end

  generate
    if (S == 0) begin : g_pass
      assign y   = v;
      assign sat = neg_sat;
    end else if (ROUND_MODE == 0) begin : g_trunc
      logic unused_lsb;
      assign y          = v[DDS_WIDTH-1:S];
      assign sat        = neg_sat;
      assign unused_lsb = ^v[S-1:0];
    end else begin : g_round
      localparam logic [DDS_WIDTH:0] HALF = (DDS_WIDTH+1)'(1) << (S-1);
      logic [DDS_WIDTH:0] sum;
      logic [O_WIDTH:0]   sh;
      logic               ovf;
      logic               unused_lsb;
      // One guard bit catches the only possible overflow: positive wrap.
      assign sum        = {v[DDS_WIDTH-1], v} + HALF;
      assign sh         = sum[DDS_WIDTH:S];
      assign ovf        = sh[O_WIDTH] != sh[O_WIDTH-1];
      assign y          = ovf ? OMAX : sh[O_WIDTH-1:0];
      assign sat        = neg_sat | ovf;
      assign unused_lsb = ^sum[S-1:0];
    end
  endgenerate
endmodule

module nco_iq_unpack_axis #(
  parameter int I_WIDTH      = 32,
  parameter int DDS_WIDTH    = 16,
  parameter int O_WIDTH      = 12,
  parameter int ROUND_MODE   = 0,
  parameter int ZERO_ON_IDLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               conj,
  input  logic [I_WIDTH-1:0] s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [O_WIDTH-1:0] m_cos,
  output logic [O_WIDTH-1:0] m_sin,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [15:0]        ovf_cnt
);
  localparam int HW = I_WIDTH / 2;

  typedef struct packed {
    logic [O_WIDTH-1:0] sin;
    logic [O_WIDTH-1:0] cos;
  } beat_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state, state_nxt;
  beat_t  main_q, skid_q, beat_in;

  logic [1:0][DDS_WIDTH-1:0] lane_in;
  logic [1:0][O_WIDTH-1:0]   lane_out;
  logic [1:0]                lane_sat;
  logic                      acc, xfer;
  logic                      load_main, load_skid, skid_to_main;

  assign lane_in[0] = s_axis_tdata[DDS_WIDTH-1:0];
  assign lane_in[1] = s_axis_tdata[HW+DDS_WIDTH-1:HW];

  generate
    if (DDS_WIDTH < HW) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^{s_axis_tdata[I_WIDTH-1:HW+DDS_WIDTH], s_axis_tdata[HW-1:DDS_WIDTH]};
    end
    for (genvar l = 0; l < 2; l++) begin : g_lane
      nco_iq_lane #(
        .DDS_WIDTH (DDS_WIDTH),
        .O_WIDTH   (O_WIDTH),
        .ROUND_MODE(ROUND_MODE)
      ) u_lane (
        .x  (lane_in[l]),
        .neg((l == 1) && conj),
        .y  (lane_out[l]),
        .sat(lane_sat[l])
      );
    end
  endgenerate

  assign beat_in       = '{sin: lane_out[1], cos: lane_out[0]};
  assign s_axis_tready = enable && (state != FULL);
  assign m_axis_tvalid = (state != EMPTY);
  assign acc           = s_axis_tvalid && s_axis_tready;
  assign xfer          = enable && m_axis_tvalid && m_axis_tready;

  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      EMPTY: if (acc) begin
        state_nxt = ONE;
        load_main = 1'b1;
      end
      ONE: begin
        if (acc && xfer) load_main = 1'b1;
        else if (acc) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (xfer) state_nxt = EMPTY;
      end
      FULL: if (xfer) begin
        state_nxt    = ONE;
        skid_to_main = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ovf_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load_main)    main_q <= beat_in;
      if (skid_to_main) main_q <= skid_q;
      if (load_skid)    skid_q <= beat_in;
      if (acc)          ovf_cnt <= ovf_cnt + 16'(lane_sat[0]) + 16'(lane_sat[1]);
    end
  end

  generate
    if (ZERO_ON_IDLE != 0) begin : g_zero
      assign m_cos = m_axis_tvalid ? main_q.cos : '0;
      assign m_sin = m_axis_tvalid ? main_q.sin : '0;
    end else begin : g_hold
      assign m_cos = main_q.cos;
      assign m_sin = main_q.sin;
    end
  endgenerate
endmodule

// File: tb/tb_nco_iq_unpack_axis.sv
// Directed bench: a truncating and a rounding instance share one stimulus stream.
module tb_nco_iq_unpack_axis;
  logic        clk = 0;
  logic        rst, enable, conj, s_valid, m_ready;
  logic [31:0] tdata;
  logic        s_ready_t, s_ready_r, m_valid_t, m_valid_r;
  logic [11:0] cos_t, sin_t, cos_r, sin_r;
  logic [15:0] ovf_t, ovf_r;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  nco_iq_unpack_axis #(.ROUND_MODE(0)) dut_t (
    .clk(clk), .rst(rst), .enable(enable), .conj(conj),
    .s_axis_tdata(tdata), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready_t),
    .m_cos(cos_t), .m_sin(sin_t), .m_axis_tvalid(m_valid_t),
    .m_axis_tready(m_ready), .ovf_cnt(ovf_t)
  );

  nco_iq_unpack_axis #(.ROUND_MODE(1)) dut_r (
    .clk(clk), .rst(rst), .enable(enable), .conj(conj),
    .s_axis_tdata(tdata), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready_r),
    .m_cos(cos_r), .m_sin(sin_r), .m_axis_tvalid(m_valid_r),
    .m_axis_tready(m_ready), .ovf_cnt(ovf_r)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_t(input string tag, input logic v, input logic [11:0] c, input logic [11:0] s);
    chk({tag, ".vld"}, 32'(m_valid_t), 32'(v));
    chk({tag, ".cos"}, 32'(cos_t), 32'(c));
    chk({tag, ".sin"}, 32'(sin_t), 32'(s));
  endtask

  task automatic drive(input logic [15:0] c, input logic [15:0] s, input logic cj);
    tdata   = {s, c};
    conj    = cj;
    s_valid = 1'b1;
  endtask

  initial begin
    rst = 1; enable = 1; conj = 0; s_valid = 0; m_ready = 1; tdata = '0;
    tick(); tick();
    rst = 0;
    chk_t("reset", 1'b0, 12'h000, 12'h000);
    chk("reset.ovf", 32'(ovf_t), 32'h0);
    chk("reset.rdy", 32'(s_ready_t), 32'h1);

    // Streaming at one beat per clock with sink always ready
    drive(16'h0123, 16'hFEDC, 0); tick();
    chk_t("b1", 1'b1, 12'h012, 12'hFED);
    chk("b1.r.cos", 32'(cos_r), 32'h012);
    chk("b1.r.sin", 32'(sin_r), 32'hFEE);
    chk("b1.rdy", 32'(s_ready_t), 32'h1);

    drive(16'h7FFF, 16'h0018, 0); tick();
    chk_t("b2", 1'b1, 12'h7FF, 12'h001);
    chk("b2.ovf_t", 32'(ovf_t), 32'h0);
    chk("b2.r.cos", 32'(cos_r), 32'h7FF);
    chk("b2.r.sin", 32'(sin_r), 32'h002);
    chk("b2.ovf_r", 32'(ovf_r), 32'h1);
    chk("b2.rdy", 32'(s_ready_t), 32'h1);

    drive(16'h0000, 16'h8000, 1); tick();
    chk_t("b3", 1'b1, 12'h000, 12'h7FF);
    chk("b3.ovf_t", 32'(ovf_t), 32'h1);
    chk("b3.r.sin", 32'(sin_r), 32'h7FF);
    chk("b3.ovf_r", 32'(ovf_r), 32'h2);

    drive(16'h0000, 16'h0010, 1); tick();
    chk_t("b4", 1'b1, 12'h000, 12'hFFF);
    chk("b4.r.sin", 32'(sin_r), 32'hFFF);
    chk("b4.ovf_t", 32'(ovf_t), 32'h1);
    chk("b4.rdy", 32'(s_ready_t), 32'h1);

    s_valid = 0; conj = 0; tick();
    chk_t("idle", 1'b0, 12'h000, 12'h000);

    // Backpressure: A, B accepted, C stalled
    m_ready = 0;
    drive(16'h0100, 16'h0200, 0); tick();
    chk_t("A", 1'b1, 12'h010, 12'h020);
    chk("A.rdy", 32'(s_ready_t), 32'h1);
    drive(16'h0300, 16'h0400, 0); tick();
    chk_t("B.held", 1'b1, 12'h010, 12'h020);
    chk("B.rdy", 32'(s_ready_t), 32'h0);
    drive(16'h0500, 16'h0600, 0); tick();
    chk_t("C.stall", 1'b1, 12'h010, 12'h020);
    chk("C.rdy", 32'(s_ready_t), 32'h0);

    // Global stall with full buffer and ready sink
    enable = 0; m_ready = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_t("stall", 1'b1, 12'h010, 12'h020);
      chk("stall.rdy", 32'(s_ready_t), 32'h0);
    end
    enable = 1; tick();
    chk_t("drainB", 1'b1, 12'h030, 12'h040);
    chk("drainB.rdy", 32'(s_ready_t), 32'h1);
    tick();
    s_valid = 0;
    chk_t("drainC", 1'b1, 12'h050, 12'h060);
    tick();
    chk_t("drained", 1'b0, 12'h000, 12'h000);
    chk("drained.ovf", 32'(ovf_t), 32'h1);

    // Reset while full
    m_ready = 0;
    drive(16'h0700, 16'h0800, 0); tick();
    drive(16'h0900, 16'h0A00, 0); tick();
    chk("full.rdy", 32'(s_ready_t), 32'h0);
    s_valid = 0; rst = 1; tick();
    rst = 0;
    chk_t("rstfull", 1'b0, 12'h000, 12'h000);
    chk("rstfull.ovf", 32'(ovf_t), 32'h0);
    chk("rstfull.rdy", 32'(s_ready_t), 32'h1);
    m_ready = 1;
    drive(16'h0123, 16'hFEDC, 0); tick();
    s_valid = 0;
    chk_t("postrst", 1'b1, 12'h012, 12'hFED);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/nco_iq_unpack_axis.md
Name: nco_iq_unpack_axis

Overview:
- Parametrised successor to the single-cycle NCO cos/sin splitter.
- Unpacks a packed DDS AXI-Stream word (cos in the low lane, sin in the high lane) into signed I/Q samples of configurable width.
- Provides selectable truncate or round-with-saturation width reduction, and a run-time conjugate (sin negation).
- Adds full AXI-Stream backpressure through a 2-entry skid buffer. Sits between the DDS core and the mixers / Costas loop.

Parameters:
I_WIDTH  32  packed tdata width; two lanes of I_WIDTH/2 bits each (must be even)
DDS_WIDTH  16  valid sign-extended sample bits at the bottom of each lane; DDS_WIDTH <= I_WIDTH/2
O_WIDTH  12  output sample width; 2 <= O_WIDTH <= DDS_WIDTH
ROUND_MODE  0  0 = truncate (drop LSBs); 1 = round half-up with saturation
ZERO_ON_IDLE  1  1 = data outputs forced to 0 when m_axis_tvalid=0; 0 = hold last sample

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  global stall; 0 freezes all state
conj  in  1  1 = output -sin (complex conjugate); sampled with each accepted input beat
s_axis_tdata  in  I_WIDTH  packed DDS word: cos [DDS_WIDTH-1:0], sin [I_WIDTH/2+DDS_WIDTH-1:I_WIDTH/2]
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_cos  out  O_WIDTH  signed cos sample
m_sin  out  O_WIDTH  signed sin sample (negated if conj)
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
ovf_cnt  out  16  count of saturation events, wraps at 0xFFFF -> 0

Behaviour:
- Reset (rst=1 at a clk edge, overrides enable): both buffer entries empty, m_axis_tvalid=0, m_cos=m_sin=0, ovf_cnt=0.
- s_axis_tready = enable & ~skid_full. It is driven only from registers; it has no combinational path from m_axis_tready.
- Input accept: s_axis_tvalid & s_axis_tready at a clk edge.
- Output transfer: m_axis_tvalid & m_axis_tready at a clk edge.
- Latency: with an empty buffer and a ready sink, an accepted beat appears on m_* at the next edge (1 cycle).
- Arithmetic, in order, per lane:
  - Extract DDS_WIDTH bits, signed.
  - If conj, negate the sin lane at DDS_WIDTH. -2^(DDS_WIDTH-1) saturates to 2^(DDS_WIDTH-1)-1 and counts as one saturation.
  - Reduce by S = DDS_WIDTH-O_WIDTH bits:
    - Truncate: arithmetic shift right by S.
    - Round: add 2^(S-1), shift right by S; a positive overflow clamps to 2^(O_WIDTH-1)-1 and counts as a saturation.
  - If S=0, pass through and do not round.
- ovf_cnt increments by the number of saturation events in the accepted beat (0, 1 or 2; max 2 per beat: one per lane). It increments at the accept edge.
- Skid buffer, states by occupancy:
  - EMPTY: accept -> ONE.
  - ONE: accept with no transfer -> FULL (the new beat goes to the skid register); accept with transfer -> ONE (main register reloads); transfer only -> EMPTY.
  - FULL: s_axis_tready=0; transfer -> ONE (skid moves to main at the same edge).
  - Order is strictly FIFO.
- enable=0: no accept and no transfer, even if m_axis_tready=1. m_axis_tvalid, m_cos, m_sin and ovf_cnt hold. s_axis_tready=0.
- enable=0 does not drop data: the held beat remains presented.
- Downstream rule: sinks must gate their transfers with enable.
- ZERO_ON_IDLE=1: m_cos=m_sin=0 whenever m_axis_tvalid=0. ZERO_ON_IDLE=0: they keep their last value.
- While m_axis_tvalid=1 and no transfer occurs, m_cos, m_sin and m_axis_tvalid are stable (AXI rule).
- Reset mid-stream discards both buffered beats; the first beat after reset is accepted on the first enabled cycle.

Test Plan:
1. Defaults, sink always ready, input cos=0x0123, sin=0xFEDC -> next cycle m_cos=0x012, m_sin=0xFED, tvalid=1; steady stream at 1 beat/clk with s_axis_tready continuously 1.
2. ROUND_MODE=1, cos=0x7FFF, sin=0x0018 -> m_cos=0x7FF (saturated), m_sin=0x002, ovf_cnt=1; under truncate -> 0x7FF, 0x001, ovf_cnt=0.
3. conj=1, sin=0x8000, cos=0x0000, truncate -> m_sin=0x7FF, m_cos=0x000, ovf_cnt=1; conj=1, sin=0x0010 -> m_sin=0xFFF.
4. m_axis_tready=0 while 3 beats A,B,C are offered -> A and B accepted, s_axis_tready=0 from the cycle after B, C stalled; release ready -> A, B, C delivered in order with none lost or duplicated.
5. enable=0 for 5 cycles with FULL buffer and m_axis_tready=1 -> no transfer, outputs frozen; enable=1 -> draining resumes.
6. rst pulse while FULL -> next cycle m_axis_tvalid=0, m_cos=m_sin=0, ovf_cnt=0, s_axis_tready=1 (enable=1).
